// File: rtl/mc_controller.sv
// Multicycle MIPS-subset main controller: Moore FSM sequencing fetch/decode/execute
// plus ALU-control decode and the PC-enable combine with the ALU zero flag.
module mc_controller #(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } aluop_t;

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pcwrite, branch, branchne;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALU_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        done     = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000000:            state_d = RTYPEEX;
                    6'b000100:            state_d = BEQEX;
                    6'b001000:            state_d = ADDIEX;
                    6'b000010:            state_d = JEX;
                    6'b000101: begin
                        if (BNE_EN) begin
                            state_d = BNEEX;
                        end else begin
                            state_d = FETCH;
                            done    = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcode retires here without touching state
                        state_d = FETCH;
                        done    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                done     = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                done     = 1'b1;
                state_d  = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                done     = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            BNEEX: begin
                alusrca  = 1'b1;
                aluop    = ALU_SUB;
                pcsrc    = 2'b01;
                branchne = 1'b1;
                done     = 1'b1;
                state_d  = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                done     = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALU_SUB: alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero) | (branchne & ~zero);
    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction state paths and control rows taken
// from the instruction-class tables, random instruction streams, reset cases.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, done;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic [5:0] op_b, funct_b;
    logic       zero_b;
    logic       pcen_b, memwrite_b, irwrite_b, regwrite_b, alusrca_b, iord_b, memtoreg_b, regdst_b, done_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [2:0] alucontrol_b;
    logic [3:0] state_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .done(done), .state(state)
    );

    mc_controller #(.BNE_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .op(op_b), .funct(funct_b), .zero(zero_b),
        .pcen(pcen_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .regwrite(regwrite_b),
        .alusrca(alusrca_b), .iord(iord_b), .memtoreg(memtoreg_b), .regdst(regdst_b),
        .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .alucontrol(alucontrol_b),
        .done(done_b), .state(state_b)
    );

    typedef int path_t[$];

    // aluk: 0 = alucontrol not specified, 1 = add, 2 = sub, 3 = funct
    typedef struct packed {
        logic       memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
        logic [1:0] alusrcb, pcsrc;
        logic       pcwrite, branch, branchne, done;
        logic [1:0] aluk;
    } row_t;

    function automatic path_t exp_path(input logic [5:0] o);
        path_t p;
        case (o)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b000100: p = '{0, 1, 8};
            6'b000101: p = '{0, 1, 12};
            6'b001000: p = '{0, 1, 9, 10};
            6'b000010: p = '{0, 1, 11};
            default:   p = '{0, 1};
        endcase
        return p;
    endfunction

    function automatic row_t exp_row(input int st, input bit illegal);
        row_t r;
        r = '0;
        case (st)
            0:  begin r.alusrcb = 2'b01; r.irwrite = 1; r.pcwrite = 1; r.aluk = 1; end
            1:  begin r.alusrcb = 2'b11; r.aluk = 1; r.done = illegal; end
            2:  begin r.alusrca = 1; r.alusrcb = 2'b10; r.aluk = 1; end
            3:  r.iord = 1;
            4:  begin r.memtoreg = 1; r.regwrite = 1; r.done = 1; end
            5:  begin r.iord = 1; r.memwrite = 1; r.done = 1; end
            6:  begin r.alusrca = 1; r.aluk = 3; end
            7:  begin r.regdst = 1; r.regwrite = 1; r.done = 1; end
            8:  begin r.alusrca = 1; r.aluk = 2; r.pcsrc = 2'b01; r.branch = 1; r.done = 1; end
            9:  begin r.alusrca = 1; r.alusrcb = 2'b10; r.aluk = 1; end
            10: begin r.regwrite = 1; r.done = 1; end
            11: begin r.pcsrc = 2'b10; r.pcwrite = 1; r.done = 1; end
            12: begin r.alusrca = 1; r.aluk = 2; r.pcsrc = 2'b01; r.branchne = 1; r.done = 1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Starts and ends at a falling edge; each loop step checks the current
    // cycle and then advances one cycle. zmode: 0/1 fixed zero, 2 random.
    task automatic exec_instr(input logic [5:0] iop, input logic [5:0] ifn,
                              input int zmode, input int ncyc, input string tag);
        path_t      p;
        row_t       r;
        logic [12:0] got, want;
        logic [2:0] want_alu;
        p = exp_path(iop);
        for (int c = 0; c < p.size() && c < ncyc; c++) begin
            if (p[c] == 1 || p[c] == 2 || p[c] == 6) begin
                op = iop; funct = ifn;
            end else begin
                op = 6'($urandom); funct = 6'($urandom);
            end
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            r = exp_row(p[c], p.size() == 2);
            total++;
            if (state !== 4'(p[c])) begin
                bad++;
                $display("FAIL %s state c%0d: got %0d want %0d", tag, c, state, p[c]);
            end
            got  = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                    alusrcb, pcsrc, done};
            want = {r.pcwrite | (r.branch & zero) | (r.branchne & ~zero), r.memwrite,
                    r.irwrite, r.regwrite, r.alusrca, r.iord, r.memtoreg, r.regdst,
                    r.alusrcb, r.pcsrc, r.done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s ctrl st%0d: got %b want %b", tag, p[c], got, want);
            end
            if (r.aluk != 0) begin
                want_alu = (r.aluk == 1) ? 3'b010 : (r.aluk == 2) ? 3'b110 : alu_of_funct(ifn);
                total++;
                if (alucontrol !== want_alu) begin
                    bad++;
                    $display("FAIL %s alucontrol st%0d: got %b want %b", tag, p[c], alucontrol, want_alu);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
            @(negedge clk);
            #1;
            total++;
            if (state !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got st=%0d mw=%b rw=%b want st=0 mw=0 rw=0", state, memwrite, regwrite);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || irwrite !== 1'b1 || pcen !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got st=%0d ir=%b pcen=%b done=%b want 0 1 1 0", state, irwrite, pcen, done);
        end
    endtask

    task automatic test_lw();
        exec_instr(6'b100011, 6'($urandom), 2, 99, "lw");
    endtask

    task automatic test_rtype();
        exec_instr(6'b000000, 6'b100010, 2, 99, "sub");
        exec_instr(6'b000000, 6'b100100, 2, 99, "and");
        exec_instr(6'b000000, 6'b100101, 2, 99, "or");
        exec_instr(6'b000000, 6'b101010, 2, 99, "slt");
        exec_instr(6'b000000, 6'b111111, 2, 99, "rdef");
        exec_instr(6'b101011, 6'($urandom), 2, 99, "sw");
    endtask

    task automatic test_branches();
        exec_instr(6'b000100, 6'($urandom), 1, 99, "beq_z1");
        exec_instr(6'b000100, 6'($urandom), 0, 99, "beq_z0");
        exec_instr(6'b000101, 6'($urandom), 1, 99, "bne_z1");
        exec_instr(6'b000101, 6'($urandom), 0, 99, "bne_z0");
    endtask

    task automatic test_illegal();
        exec_instr(6'b111111, 6'($urandom), 2, 99, "illegal");
        exec_instr(6'b000001, 6'($urandom), 2, 99, "illegal1");
    endtask

    task automatic test_bne_disabled();
        do_reset();
        op = 6'b111111;
        op_b = 6'b000101;
        #1;
        total++;
        if (state_b !== 4'd0 || done_b !== 1'b0) begin
            bad++;
            $display("FAIL bne_off_fetch: got st=%0d done=%b want 0 0", state_b, done_b);
        end
        @(negedge clk);
        #1;
        total++;
        if (state_b !== 4'd1 || done_b !== 1'b1 || regwrite_b !== 1'b0 || memwrite_b !== 1'b0) begin
            bad++;
            $display("FAIL bne_off_decode: got st=%0d done=%b rw=%b mw=%b want 1 1 0 0",
                     state_b, done_b, regwrite_b, memwrite_b);
        end
        @(negedge clk);
        #1;
        total++;
        if (state_b !== 4'd0) begin
            bad++;
            $display("FAIL bne_off_return: got st=%0d want 0", state_b);
        end
        op_b = 6'b000000;
        do_reset();
    endtask

    task automatic test_reset_mid_sw();
        exec_instr(6'b101011, 6'($urandom), 2, 3, "sw_pre");
        op = 6'($urandom);
        #1;
        total++;
        if (state !== 4'd5 || memwrite !== 1'b1) begin
            bad++;
            $display("FAIL sw_memwr: got st=%0d mw=%b want 5 1", state, memwrite);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
            bad++;
            $display("FAIL sw_reset: got st=%0d mw=%b rw=%b want 0 0 0", state, memwrite, regwrite);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        exec_instr(6'b000010, 6'($urandom), 2, 99, "j");
        exec_instr(6'b001000, 6'($urandom), 2, 3, "addi");
        #1;
        cyc = 3;
        total++;
        if (state !== 4'd10 || regwrite !== 1'b1 || cyc + 1 != exp_path(6'b001000).size()) begin
            bad++;
            $display("FAIL addi_wb: got st=%0d rw=%b want 10 1", state, regwrite);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] o, f;
        logic [5:0] legal_ops [7];
        logic [5:0] functs [5];
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
        functs    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 60; i++) begin
            o = ($urandom_range(0, 8) < 7) ? legal_ops[$urandom_range(0, 6)] : 6'($urandom);
            f = ($urandom_range(0, 1) == 1) ? functs[$urandom_range(0, 4)] : 6'($urandom);
            exec_instr(o, f, 2, 99, "rand");
        end
    endtask

    initial begin
        reset = 1'b1;
        op = '0; funct = '0; zero = 1'b0;
        op_b = '0; funct_b = '0; zero_b = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_branches();
        test_illegal();
        test_back_to_back();
        test_reset_mid_sw();
        test_bne_disabled();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter BNE_EN, default 1, meaning 1 enables bne decode and 0 treats bne as an illegal opcode.
REQ-002 SHALL have port clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports op  in  6  instruction opcode and funct  in  6  R-type function field.
REQ-005 SHALL have port zero  in  1  ALU zero flag, valid combinationally during the execute cycle.
REQ-006 SHALL have 1-bit outputs pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, each a datapath enable or 2:1 select.
REQ-007 SHALL have 2-bit outputs alusrcb and pcsrc as 3/4-input datapath mux selects, and 3-bit output alucontrol.
REQ-008 SHALL have output done  1  high during the final cycle of each instruction, and output state  4  current FSM state for debug.

Function
REQ-009 SHALL be a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
REQ-010 SHALL take transitions FETCH->DECODE, MEMRD->MEMWB, RTYPEEX->RTYPEWB, ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, ADDIWB and JEX SHALL each go to FETCH.
REQ-011 SHALL dispatch from DECODE on op: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000101->BNEEX (BNE_EN=1 only), 001000->ADDIEX, 000010->JEX.
REQ-012 SHALL send any other op from DECODE to FETCH with no register or memory write.
REQ-013 SHALL go from MEMADR to MEMRD if op=100011, else MEMWR.
REQ-014 SHALL drive default output values of 0 in every state, overridden per REQ-015..REQ-021.
REQ-015 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, irwrite=1, pcwrite=1.
REQ-016 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=add; MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=add.
REQ-017 MEMRD SHALL drive iord=1; MEMWR SHALL drive iord=1, memwrite=1; MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1.
REQ-018 RTYPEEX SHALL drive alusrca=1, alusrcb=00, aluop=funct; RTYPEWB SHALL drive regdst=1, memtoreg=0, regwrite=1; ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1.
REQ-019 BEQEX/BNEEX SHALL drive alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, and branch/branchne=1 respectively.
REQ-020 JEX SHALL drive pcsrc=10, pcwrite=1.
REQ-021 SHALL compute pcen = pcwrite | (branch & zero) | (branchne & ~zero), combinationally from state and zero.
REQ-022 SHALL decode alucontrol as add->010 and sub->110.
REQ-023 SHALL decode aluop=funct via funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, and any other funct->010.
REQ-024 SHALL assert done in MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, ADDIWB, JEX, and in DECODE on an illegal opcode.
REQ-025 SHALL give instruction latencies, counted FETCH to done inclusive, of lw=5, sw=4, R-type=4, addi=4, beq/bne=3, j=3, illegal=2.
REQ-026 SHALL sample op and funct only in DECODE/MEMADR/RTYPEEX; changes in other states SHALL have no effect.

Reset
REQ-027 SHALL enter FETCH on the next rising edge whenever reset=1 at that edge, including mid-instruction, and hold FETCH while reset stays high.
REQ-028 SHALL assert no memwrite and no regwrite during any cycle in which state=FETCH after reset.
REQ-029 The cycle after reset deasserts SHALL be the first FETCH, with irwrite=1 and pcen=1.

Verification
REQ-030 lw (op=100011) from reset release: state SHALL sequence 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; done=1 only in state 4.
REQ-031 R-type sub (op=0, funct=100010): alucontrol=110 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB; return to FETCH after 4 cycles.
REQ-032 beq with zero=1 gives pcen=1 and pcsrc=01 in BEQEX; beq with zero=0 gives pcen=0; bne inverts both cases; with BNE_EN=0, op=000101 gives DECODE->FETCH and done=1.
REQ-033 Illegal op=111111: state SHALL go 0,1,0; memwrite and regwrite stay 0 throughout.
REQ-034 Assert reset during MEMWR (sw): next state SHALL be 0 and memwrite=0 in that cycle.
REQ-035 Back-to-back j then addi: JEX drives pcsrc=10 and pcen=1; the following FETCH starts immediately, and ADDIWB reaches regwrite=1 four cycles later.
